alu_operand_loader: RTL

Pin-limited front end for the 8-bit ALU stage. It collects operand A, operand B and the 3-bit operation selector serially over one 8-bit input bus using a load strobe. It then holds them stable on the ALU's combinational inputs for one execute cycle and registers the ALU's result and Zero flag, marked with a valid flag. It sits directly upstream of the ALU and also captures the ALU's output, so the top level exposes a registered, handshaked result instead of raw combinational pins.

---
 rtl/alu_operand_loader_if.sv | 28 ++
 rtl/alu_operand_loader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_loader_if.sv
// Bus bundle for alu_operand_loader: serial load port, ALU operand/result
// pins and the registered, handshaked result.
interface alu_operand_loader_if;
  logic       ena;
  logic [7:0] data_in;
  logic       load;
  logic       abort;
  logic       ready;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic [7:0] result;
  logic       zero;
  logic       result_valid;
  logic       overrun;

  modport master (
    output ena, data_in, load, abort, alu_result, alu_zero,
    input  ready, alu_a, alu_b, alu_sel, result, zero, result_valid, overrun
  );

  modport slave (
    input  ena, data_in, load, abort, alu_result, alu_zero,
    output ready, alu_a, alu_b, alu_sel, result, zero, result_valid, overrun
  );
endinterface

// File: rtl/alu_operand_loader.sv
// Serial operand/selector loader in front of the 8-bit combinational ALU; captures its result.
// Optional macro LOAD_SYNC_EN: load goes through a 2-flop synchronizer and rising-edge detector.
module alu_operand_loader (
  input logic                 clk,
  input logic                 rst,
  alu_operand_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_SEL  = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t     state_r;
  state_t     state_nx_s;
  logic       strobe_s;
  logic       cap_a_s;
  logic       cap_b_s;
  logic       cap_sel_s;
  logic       cap_res_s;
  logic       clr_valid_s;
  logic       set_ovr_s;
  logic       clr_ovr_s;

  logic       ready_r;
  logic [7:0] alu_a_r;
  logic [7:0] alu_b_r;
  logic [2:0] alu_sel_r;
  logic [7:0] result_r;
  logic       zero_r;
  logic       result_valid_r;
  logic       overrun_r;

`ifdef LOAD_SYNC_EN
  // Bits [1:0] form the synchronizer; bit [2] is the previous synchronized value.
  logic [2:0] load_sync_r;

  // Load synchronizer and edge history, frozen while the block is disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_sync_r <= 3'b000;
    end else if (bus.ena) begin
      load_sync_r <= {load_sync_r[1:0], bus.load};
    end else begin
      load_sync_r <= load_sync_r;
    end
  end

  assign strobe_s = load_sync_r[1] & ~load_sync_r[2];
`else
  assign strobe_s = bus.load;
`endif

  // Next-state decode and per-register capture strobes
  always_comb begin
    state_nx_s  = state_r;
    cap_a_s     = 1'b0;
    cap_b_s     = 1'b0;
    cap_sel_s   = 1'b0;
    cap_res_s   = 1'b0;
    clr_valid_s = 1'b0;
    set_ovr_s   = 1'b0;
    clr_ovr_s   = 1'b0;
    if (!bus.ena) begin
      state_nx_s = state_r;
    end else if (bus.abort) begin
      // abort outranks any load seen in the same cycle
      state_nx_s  = S_A;
      clr_valid_s = 1'b1;
      clr_ovr_s   = 1'b1;
    end else begin
      case (state_r)
        S_A: begin
          if (strobe_s) begin
            cap_a_s    = 1'b1;
            state_nx_s = S_B;
          end else begin
            state_nx_s = S_A;
          end
        end
        S_B: begin
          if (strobe_s) begin
            cap_b_s    = 1'b1;
            state_nx_s = S_SEL;
          end else begin
            state_nx_s = S_B;
          end
        end
        S_SEL: begin
          if (strobe_s) begin
            cap_sel_s  = 1'b1;
            state_nx_s = S_EXEC;
          end else begin
            state_nx_s = S_SEL;
          end
        end
        S_EXEC: begin
          cap_res_s  = 1'b1;
          set_ovr_s  = strobe_s;
          state_nx_s = S_DONE;
        end
        S_DONE: begin
          if (strobe_s) begin
            cap_a_s     = 1'b1;
            clr_valid_s = 1'b1;
            state_nx_s  = S_B;
          end else begin
            state_nx_s = S_DONE;
          end
        end
        default: begin
          state_nx_s = S_A;
        end
      endcase
    end
  end

  // State register with ready pre-decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_A;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_nx_s;
      ready_r <= (state_nx_s != S_EXEC);
    end
  end

  // Operand and selector registers driving the ALU
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_r   <= 8'h00;
      alu_b_r   <= 8'h00;
      alu_sel_r <= 3'b000;
    end else begin
      alu_a_r   <= cap_a_s   ? bus.data_in      : alu_a_r;
      alu_b_r   <= cap_b_s   ? bus.data_in      : alu_b_r;
      alu_sel_r <= cap_sel_s ? bus.data_in[2:0] : alu_sel_r;
    end
  end

  // Result capture, valid flag and sticky overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_r       <= 8'h00;
      zero_r         <= 1'b0;
      result_valid_r <= 1'b0;
      overrun_r      <= 1'b0;
    end else begin
      if (cap_res_s) begin
        result_r <= bus.alu_result;
        zero_r   <= bus.alu_zero;
      end else begin
        result_r <= result_r;
        zero_r   <= zero_r;
      end
      if (cap_res_s) begin
        result_valid_r <= 1'b1;
      end else if (clr_valid_s) begin
        result_valid_r <= 1'b0;
      end else begin
        result_valid_r <= result_valid_r;
      end
      if (clr_ovr_s) begin
        overrun_r <= 1'b0;
      end else if (set_ovr_s) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign bus.ready        = ready_r;
  assign bus.alu_a        = alu_a_r;
  assign bus.alu_b        = alu_b_r;
  assign bus.alu_sel      = alu_sel_r;
  assign bus.result       = result_r;
  assign bus.zero         = zero_r;
  assign bus.result_valid = result_valid_r;
  assign bus.overrun      = overrun_r;

endmodule
